spi_slave_mode: RTL and testbench

- Parametrised SPI slave for the FPGA fabric, sitting between an external SPI master and the on-chip register/stream logic. Supports all four SPI modes (CPOL/CPHA, runtime-selected), configurable word width, and MSB- or LSB-first order.
- Provides a one-deep TX holding register with valid/ready handshake and a one-cycle RX strobe.
- Reports underrun (no TX word queued) and aborted frames (ss released mid-word).

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_slave_mode_sync.sv | 37 +++
 rtl/spi_slave_mode.sv | 208 ++++++++++++++++++++
 tb/tb_spi_slave_mode.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: mode-bit positions, FSM states and
// bit-counter sizing.
package spi_pkg;

  localparam int unsigned CPOL_BIT = 1;
  localparam int unsigned CPHA_BIT = 0;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_state_e;

  function automatic int unsigned bit_cnt_width(input int unsigned data_width);
    return (data_width > 2) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/spi_slave_mode_sync.sv
// Multi-flop synchroniser for an asynchronous input plus an edge register;
// reports the synchronised level and one-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_mode.sv
// SPI slave supporting all four CPOL/CPHA modes, configurable word width and
// bit order, with a one-deep TX holding register and a one-cycle RX strobe.
module spi_slave_mode
  import spi_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter bit                    MSB_FIRST   = 1'b1,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE     = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ss,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  underrun,
  output logic                  frame_abort
);

  localparam int unsigned   CW       = bit_cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  function automatic logic out_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], b} : {b, w[DATA_WIDTH-1:1]};
  endfunction

  logic sck_level, sck_rise, sck_fall;
  logic ss_level, ss_rise, ss_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sck),
    .level(sck_level),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (ss),
    .level(ss_level),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  // mosi needs no edge flop; its last stage lines up with the sck level used for edges
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

  spi_state_e            state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  frame_abort_q, frame_abort_d;
  logic                  miso_q, miso_d;

  logic cpol, cpha, sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic load, load_cpha;

  assign cpol        = mode_q[CPOL_BIT];
  assign cpha        = mode_q[CPHA_BIT];
  assign sck_edge    = (sck_rise | sck_fall) & ~ss_level;
  assign lead_edge   = sck_edge & (sck_level != cpol);
  assign trail_edge  = sck_edge & (sck_level == cpol);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    underrun_d    = 1'b0;
    frame_abort_d = 1'b0;
    miso_d        = miso_q;
    load          = 1'b0;
    load_cpha     = cpha;

    case (state_q)
      IDLE: begin
        miso_d = 1'b1;
        if (ss_fall) begin
          state_d   = ACTIVE;
          mode_d    = mode;
          cnt_d     = '0;
          load      = 1'b1;
          load_cpha = mode[CPHA_BIT];
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          miso_d  = 1'b1;
          cnt_d   = '0;
          if (cnt_q != '0) frame_abort_d = 1'b1;
        end else if (sample_edge) begin
          rx_shift_d = shift_in(rx_shift_q, mosi_s);
          if (cnt_q == CNT_LAST) begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            load       = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (shift_edge) begin
          // A zero count marks a freshly loaded word: CPHA=1 presents its first
          // bit unshifted, CPHA=0 already presented it at load time.
          if (cpha && cnt_q == '0) begin
            miso_d = out_bit(tx_shift_q);
          end else if (cnt_q != '0) begin
            tx_shift_d = shift_out(tx_shift_q);
            miso_d     = out_bit(tx_shift_d);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Load sees the holding register before any same-cycle write
    if (load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = TX_IDLE;
        underrun_d = 1'b1;
      end
      if (!load_cpha) miso_d = out_bit(tx_shift_d);
    end

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_sync_q   <= '0;
      state_q       <= IDLE;
      mode_q        <= '0;
      cnt_q         <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      underrun_q    <= 1'b0;
      frame_abort_q <= 1'b0;
      miso_q        <= 1'b1;
    end else begin
      mosi_sync_q   <= mosi_sync_d;
      state_q       <= state_d;
      mode_q        <= mode_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      underrun_q    <= underrun_d;
      frame_abort_q <= frame_abort_d;
      miso_q        <= miso_d;
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign underrun    = underrun_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_mode.sv
// Randomised bench: one SPI master drives two slaves (8-bit MSB-first and
// 16-bit LSB-first) sharing ss/sck/mosi; a word-level model predicts results.
module tb_spi_slave_mode;

  localparam int H  = 8;
  localparam int WA = 8;
  localparam int WB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, ss, sck, mosi;
  logic [1:0]    mode;
  logic          miso_a, miso_b;
  logic [WA-1:0] tx_data_a, rx_data_a;
  logic [WB-1:0] tx_data_b, rx_data_b;
  logic          tx_valid_a, tx_valid_b, tx_ready_a, tx_ready_b;
  logic          rx_valid_a, rx_valid_b, underrun_a, underrun_b, abort_a, abort_b;

  spi_slave_mode #(.DATA_WIDTH(WA), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso_a),
    .mode(mode), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .underrun(underrun_a),
    .frame_abort(abort_a)
  );

  spi_slave_mode #(.DATA_WIDTH(WB), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso_b),
    .mode(mode), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .underrun(underrun_b),
    .frame_abort(abort_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // strobe monitor
  int und_n[2], abt_n[2];
  logic [31:0] rx_log_a[$], rx_log_b[$];
  initial begin
    und_n = '{0, 0};
    abt_n = '{0, 0};
  end
  always @(negedge clk) begin
    if (rx_valid_a) rx_log_a.push_back(32'(rx_data_a));
    if (rx_valid_b) rx_log_b.push_back(32'(rx_data_b));
    if (underrun_a) und_n[0]++;
    if (underrun_b) und_n[1]++;
    if (abort_a) abt_n[0]++;
    if (abort_b) abt_n[1]++;
  end

  // reference model state
  logic        mosi_bits[256];
  logic        cap_a[256], cap_b[256];
  logic        hfull[2];
  logic [31:0] hval[2];
  logic [31:0] last_rx[2];

  function automatic int width_of(input int d);
    return (d == 0) ? WA : WB;
  endfunction

  function automatic logic [31:0] mask_of(input int d);
    return (32'h1 << width_of(d)) - 32'h1;
  endfunction

  // bit p of a word in transmission order
  function automatic int pos_of(input int d, input int p);
    return (d == 0) ? (width_of(d) - 1 - p) : p;
  endfunction

  task automatic set_word(input int off, input logic [31:0] val, input int d);
    for (int p = 0; p < width_of(d); p++) mosi_bits[off + p] = val[pos_of(d, p)];
  endtask

  task automatic tx_write(input int d, input logic [31:0] val);
    check_eq(d == 0 ? "tx_ready_a" : "tx_ready_b",
             32'(d == 0 ? tx_ready_a : tx_ready_b), 32'(!hfull[d]));
    if (d == 0) begin tx_data_a = val[WA-1:0]; tx_valid_a = 1'b1; end
    else        begin tx_data_b = val[WB-1:0]; tx_valid_b = 1'b1; end
    @(negedge clk);
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
    if (!hfull[d]) begin
      hfull[d] = 1'b1;
      hval[d]  = val & mask_of(d);
    end
  endtask

  task automatic verify_frame(input int d, input int nbits, input bit was_reset,
                              input int und0, input int abt0);
    int          w, full, rem, exp_und, nb, idx, nrx;
    logic [31:0] loaded[64];
    logic [31:0] got, exp;
    string       sfx;
    w       = width_of(d);
    full    = nbits / w;
    rem     = nbits % w;
    exp_und = 0;
    sfx     = (d == 0) ? "a" : "b";
    // one word is loaded at ss fall and one after every completed word
    for (int l = 0; l <= full; l++) begin
      if (hfull[d]) begin
        loaded[l] = hval[d];
        hfull[d]  = 1'b0;
      end else begin
        loaded[l] = mask_of(d);
        exp_und++;
      end
    end
    for (int k = 0; k <= full; k++) begin
      nb = (k < full) ? w : rem;
      if (nb != 0) begin
        got = '0;
        exp = '0;
        for (int p = 0; p < nb; p++) begin
          idx      = pos_of(d, p);
          got[idx] = (d == 0) ? cap_a[k*w + p] : cap_b[k*w + p];
          exp[idx] = loaded[k][idx];
        end
        check_eq($sformatf("miso_%s_w%0d", sfx, k), got, exp);
      end
    end
    nrx = (d == 0) ? rx_log_a.size() : rx_log_b.size();
    check_eq($sformatf("rx_count_%s", sfx), nrx, full);
    for (int k = 0; k < full && k < nrx; k++) begin
      exp = '0;
      for (int p = 0; p < w; p++) exp[pos_of(d, p)] = mosi_bits[k*w + p];
      got = (d == 0) ? rx_log_a.pop_front() : rx_log_b.pop_front();
      check_eq($sformatf("rx_word_%s_%0d", sfx, k), got, exp);
      last_rx[d] = exp;
    end
    if (d == 0) rx_log_a.delete(); else rx_log_b.delete();
    if (was_reset) begin
      hfull[d]   = 1'b0;
      last_rx[d] = '0;
    end
    check_eq($sformatf("underrun_%s", sfx), und_n[d] - und0, exp_und);
    check_eq($sformatf("abort_%s", sfx), abt_n[d] - abt0, (!was_reset && rem != 0) ? 1 : 0);
    check_eq($sformatf("rx_data_%s", sfx),
             (d == 0) ? 32'(rx_data_a) : 32'(rx_data_b), last_rx[d]);
    check_eq($sformatf("tx_ready_%s", sfx),
             32'(d == 0 ? tx_ready_a : tx_ready_b), 32'(!hfull[d]));
    check_eq($sformatf("miso_idle_%s", sfx), 32'(d == 0 ? miso_a : miso_b), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_miso"}, {30'd0, miso_a, miso_b}, 32'h3);
    check_eq({tag, "_rx_data"}, {rx_data_a, rx_data_b}, 32'h0);
    check_eq({tag, "_strobes"},
             {26'd0, rx_valid_a, rx_valid_b, underrun_a, underrun_b, abort_a, abort_b}, 32'h0);
    check_eq({tag, "_tx_ready"}, {30'd0, tx_ready_a, tx_ready_b}, 32'h3);
  endtask

  task automatic run_frame(input logic [1:0] m, input int nbits, input bit rst_end);
    int u0[2], a0[2];
    u0   = und_n;
    a0   = abt_n;
    mode = m;
    sck  = m[1];
    repeat (2*H) @(negedge clk);
    ss = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (!m[0]) begin
        mosi = mosi_bits[i];
        repeat (H) @(negedge clk);
        cap_a[i] = miso_a;
        cap_b[i] = miso_b;
        sck = ~m[1];
        repeat (H) @(negedge clk);
        sck = m[1];
      end else begin
        sck  = ~m[1];
        mosi = mosi_bits[i];
        repeat (H) @(negedge clk);
        cap_a[i] = miso_a;
        cap_b[i] = miso_b;
        sck = m[1];
        repeat (H) @(negedge clk);
      end
      mode = 2'($urandom);
    end
    repeat (H) @(negedge clk);
    if (rst_end) begin
      rst_n = 1'b0;
      ss    = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      ss = 1'b1;
    end
    repeat (3*H) @(negedge clk);
    verify_frame(0, nbits, rst_end, u0[0], a0[0]);
    verify_frame(1, nbits, rst_end, u0[1], a0[1]);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb;
    rst_n      = 1'b0;
    ss         = 1'b1;
    sck        = 1'b0;
    mosi       = 1'b0;
    mode       = 2'b00;
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
    tx_data_a  = '0;
    tx_data_b  = '0;
    hfull      = '{1'b0, 1'b0};
    hval       = '{32'h0, 32'h0};
    last_rx    = '{32'h0, 32'h0};
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // every mode: 8-bit word 0x3C, then a 16-bit 0x8001 LSB-first for the wide slave
    for (int m = 0; m < 4; m++) begin
      tx_write(0, 32'hA5);
      tx_write(1, 32'h1234);
      set_word(0, 32'h3C, 0);
      run_frame(2'(m), 8, 1'b0);
      tx_write(1, 32'h1234);
      set_word(0, 32'h8001, 1);
      run_frame(2'(m), 16, 1'b0);
    end

    // back-to-back words, only the first queued
    tx_write(0, 32'hA5);
    set_word(0, 32'h01, 0);
    set_word(8, 32'h02, 0);
    set_word(16, 32'h03, 0);
    run_frame(2'b00, 24, 1'b0);

    // abort after five bits, then a clean frame
    tx_write(0, 32'hA5);
    for (int i = 0; i < 5; i++) mosi_bits[i] = 1'($urandom);
    run_frame(2'b01, 5, 1'b0);
    set_word(0, 32'h3C, 0);
    run_frame(2'b01, 8, 1'b0);

    // reset mid-word, then a normal frame
    tx_write(0, 32'h5A);
    tx_write(1, 32'hBEEF);
    for (int i = 0; i < 3; i++) mosi_bits[i] = 1'($urandom);
    run_frame(2'b10, 3, 1'b1);
    tx_write(0, 32'hC3);
    set_word(0, 32'h96, 0);
    run_frame(2'b10, 8, 1'b0);

    // a write while the holding register is already full must be dropped
    tx_write(0, 32'h11);
    tx_write(0, 32'h22);
    set_word(0, 32'h77, 0);
    run_frame(2'b11, 8, 1'b0);

    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 1) == 1) tx_write(0, $urandom);
      if ($urandom_range(0, 1) == 1) tx_write(1, $urandom);
      nb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 8 * $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) mosi_bits[i] = 1'($urandom);
      run_frame(2'($urandom), nb, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
